// File: rtl/sub_serial_16b_if.sv
// sub_serial_16b_if
// Purpose : bundles the request / result signals of the nibble-serial
//           subtractor so that the requester and the subtractor share one port.
// Signals : start   - request to begin a subtraction (acted on only while idle)
//           A, B    - minuend / subtrahend, taken when start is accepted
//           busy    - operation in progress or result being presented
//           done    - one-cycle pulse, results valid
//           D       - difference A - B modulo 2^N
//           B_out   - final borrow (A < B unsigned)
//           Zero    - D == 0
//           Ofl     - two's-complement overflow of A - B
// Modports: master drives the request side, slave drives the result side.
interface sub_serial_16b_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         B_out;
  logic         Zero;
  logic         Ofl;

  modport master (
    output start, A, B,
    input  busy, done, D, B_out, Zero, Ofl
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, B_out, Zero, Ofl
  );
endinterface

// File: rtl/sub_serial_16b.sv
// sub_serial_16b
// Purpose : N-bit subtractor that processes one 4-bit nibble per clock,
//           LSB nibble first, using a 4-bit adder with inverted subtrahend
//           and a borrow flop between nibbles.
// Ports   : clk   - single clock, rising edge
//           rst_n - synchronous active-low reset
//           bus   - sub_serial_16b_if.slave (start/A/B in, busy/done/D/B_out/Zero/Ofl out)
// N must be a multiple of 4.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; result outputs hold the last result
// RUN    | one nibble subtracted per cycle, counter selects the nibble
// DONE   | results just loaded, done high for this one cycle
module sub_serial_16b #(
  parameter int N = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sub_serial_16b_if.slave  bus
);

  localparam int NIB = N / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_d;
  logic          r_bout;
  logic          r_zero;
  logic          r_ofl;
  logic          r_busy;
  logic          r_done;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [4:0]    w_sum;
  logic [N-1:0]  w_acc_next;
  logic          w_borrow_next;

  // Nibble datapath: A + ~B + ~borrow; carry out set means no borrow.
  always_comb begin
    w_a_nib       = r_a[4*r_cnt +: 4];
    w_b_nib       = r_b[4*r_cnt +: 4];
    w_sum         = {1'b0, w_a_nib} + {1'b0, ~w_b_nib} + {4'b0000, ~r_borrow};
    w_borrow_next = ~w_sum[4];
    w_acc_next    = r_acc;
    w_acc_next[4*r_cnt +: 4] = w_sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_acc    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ofl    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_acc    <= w_acc_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // Flags come from the captured operands and the fully
            // assembled difference, not from the live A/B ports.
            r_d     <= w_acc_next;
            r_bout  <= w_borrow_next;
            r_zero  <= (w_acc_next == '0);
            r_ofl   <= (r_a[N-1] ^ r_b[N-1]) & (w_acc_next[N-1] ^ r_a[N-1]);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // start is not looked at here, so a pulse in this cycle is dropped.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.D     = r_d;
  assign bus.B_out = r_bout;
  assign bus.Zero  = r_zero;
  assign bus.Ofl   = r_ofl;

endmodule

// File: doc/sub_serial_16b.md
SUB_SERIAL_16B -- requirements
Module: sub_serial_16b

Interface
REQ-001 SHALL have parameter N, default 16, operand width in bits; N SHALL be a multiple of 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  N  minuend, captured when start is accepted.
REQ-006 SHALL have port B  input  N  subtrahend, captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high in RUN and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port D  output  N  registered difference A - B, modulo 2^N.
REQ-010 SHALL have port B_out  output  1  registered final borrow; 1 iff A < B unsigned.
REQ-011 SHALL have port Zero  output  1  registered flag; 1 iff D == 0.
REQ-012 SHALL have port Ofl  output  1  registered two's-complement overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, capture A and B, clear the nibble counter and borrow flop, and go to RUN on that edge.
REQ-015 SHALL, in IDLE with start=0, stay in IDLE with all result outputs unchanged.
REQ-016 SHALL, each RUN cycle, subtract the current 4-bit nibble (LSB nibble first) as A_nib + ~B_nib + ~borrow, store the 4-bit result, update the borrow flop, and increment the counter.
REQ-017 SHALL, on the edge processing the final nibble (counter = N/4-1), load D, B_out, Zero and Ofl and go to DONE.
REQ-018 SHALL make latency exactly N/4+1 edges from the edge accepting start to the first edge with done=1; for N=16, done is high in the cycle after the 5th edge.
REQ-019 SHALL hold done=1 for exactly one cycle (DONE), then return to IDLE unconditionally.
REQ-020 SHALL ignore start in RUN and DONE; a start pulse in these states SHALL NOT be queued.
REQ-021 SHALL hold D, B_out, Zero and Ofl stable from DONE until the next accepted operation completes.
REQ-022 SHALL NOT change A or B mid-operation; changes to the A/B ports after acceptance have no effect.
REQ-023 SHALL compute B_out as the inverted carry out of the MSB nibble.
REQ-024 SHALL compute Ofl = (A[N-1] != B[N-1]) and (D[N-1] != A[N-1]), using the captured operands.
REQ-025 SHALL allow back-to-back operations: start asserted in the IDLE cycle right after DONE is accepted.

Reset
REQ-026 SHALL, when rst_n=0 at a rising edge, go to IDLE, clear the counter and borrow, and set busy=0, done=0, D=0, B_out=0, Zero=0 and Ofl=0.
REQ-027 SHALL abort an in-progress operation when reset is asserted in RUN; no done pulse SHALL follow the aborted operation.
REQ-028 SHALL give reset priority over start in the same cycle.

Verification
REQ-029 SHALL cover: A=0x0005, B=0x0003 -> done 5 edges after start, D=0x0002, B_out=0, Zero=0, Ofl=0.
REQ-030 SHALL cover: A=0x0000, B=0x0001 -> D=0xFFFF, B_out=1, Zero=0, Ofl=0.
REQ-031 SHALL cover: A=0x8000, B=0x0001 -> D=0x7FFF, B_out=0, Ofl=1. Also A=0x7FFF, B=0xFFFF -> D=0x8000, B_out=1, Ofl=1.
REQ-032 SHALL cover: A=B=0x1234 -> D=0x0000, Zero=1, B_out=0. Also A=0x0F0F, B=0x00FF -> D=0x0E10, which checks the borrow across nibbles.
REQ-033 SHALL cover: start re-pulsed with new operands during RUN -> ignored; the single done pulse reports the first operands' result.
REQ-034 SHALL cover: rst_n=0 during the 2nd RUN cycle -> next cycle busy=0, done=0, all outputs 0; no done pulse appears afterward.
